// File: rtl/z80_seq_pkg.sv
// Shared definitions for the Z80 multi-cycle instruction sequencers.
// Holds the sequencer state encoding, opcode constants and the
// Z80FI register number used by the retirement records.
package z80_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_T1 = 3'd1,
    ST_RD_T2 = 3'd2,
    ST_RD_T3 = 3'd3,
    ST_WR_T1 = 3'd4,
    ST_WR_T2 = 3'd5,
    ST_WR_T3 = 3'd6,
    ST_DONE  = 3'd7
  } seq_state_t;

  localparam logic [7:0] OPC_LD_HL_N = 8'h36;
  localparam logic [3:0] LD_HL_N_LEN = 4'd2;

  // Z80FI register numbering (same value as REG_HL in z80.vh).
  localparam logic [2:0] REG_HL = 3'd2;

endpackage

// File: rtl/z80_mem_cycle.sv
// Generic 3-T-state memory cycle bus driver.
// The owning sequencer tells it which T-state is current and whether the
// cycle is a read or a write; it drives the bus strobes and reports when
// T2 may advance (wait_n released).
// Ports:
//   i_t1/i_t2/i_t3 : current T-state of the cycle (at most one high)
//   i_wr           : 1 = write cycle, 0 = read cycle
//   i_addr         : address to present during the cycle
//   i_wdata        : byte to drive during a write cycle
//   i_wait_n       : bus wait request, only meaningful in T2
//   o_addr/o_data_out/o_mreq_n/o_rd_n/o_wr_n : bus outputs
//   o_t2_done      : T2 may advance to T3 on the next edge
module z80_mem_cycle (
  input  logic        i_t1,
  input  logic        i_t2,
  input  logic        i_t3,
  input  logic        i_wr,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  input  logic        i_wait_n,
  output logic [15:0] o_addr,
  output logic [7:0]  o_data_out,
  output logic        o_mreq_n,
  output logic        o_rd_n,
  output logic        o_wr_n,
  output logic        o_t2_done
);

  logic w_active;

  assign w_active   = i_t1 | i_t2 | i_t3;
  assign o_addr     = w_active ? i_addr : 16'h0000;
  assign o_data_out = (w_active && i_wr) ? i_wdata : 8'h00;
  assign o_mreq_n   = ~w_active;
  assign o_rd_n     = ~(w_active & ~i_wr);
  // Write strobe only in T2, so it stretches with every wait state.
  assign o_wr_n     = ~(i_t2 & i_wr);
  // Feeds next-state logic only; never reaches an output port.
  assign o_t2_done  = i_t2 & i_wait_n;

endmodule

// File: rtl/z80_ld_hl_immed_seq.sv
// Sequencer for LD (HL),n (opcode 0x36) after the M1 fetch is complete.
// Runs the M2 operand read from PC+1 and the M3 write of n to (HL),
// then retires with a one-cycle Z80FI record and the next PC.
// Ports:
//   clk, reset_n (sync, active-low)
//   start, pc_in, hl_in        : decoder handoff, sampled in IDLE only
//   busy                       : high outside IDLE
//   addr, data_in, data_out, mreq_n, rd_n, wr_n, wait_n : memory bus
//   done, pc_next              : retirement pulse and next PC
//   fi_*                       : Z80FI retirement record (zero outside DONE)
module z80_ld_hl_immed_seq
  import z80_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] pc_in,
  input  logic [15:0] hl_in,
  output logic        busy,
  output logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        mreq_n,
  output logic        rd_n,
  output logic        wr_n,
  input  logic        wait_n,
  output logic        done,
  output logic [15:0] pc_next,
  output logic        fi_valid,
  output logic [15:0] fi_insn,
  output logic [3:0]  fi_insn_len,
  output logic [15:0] fi_pc_rdata,
  output logic [15:0] fi_pc_wdata,
  output logic [2:0]  fi_reg1_rnum,
  output logic [15:0] fi_reg1_rdata,
  output logic        fi_mem_wr,
  output logic [15:0] fi_mem_addr,
  output logic [7:0]  fi_mem_wdata
);

  seq_state_t  r_state;
  logic [15:0] r_pc_q;
  logic [15:0] r_hl_q;
  logic [7:0]  r_n_q;

  logic        w_rd_phase;
  logic        w_wr_phase;
  logic        w_t1;
  logic        w_t2;
  logic        w_t3;
  logic        w_t2_done;
  logic        w_done;
  logic [15:0] w_cyc_addr;
  logic [15:0] w_pc_next;

  assign w_rd_phase = (r_state == ST_RD_T1) || (r_state == ST_RD_T2) || (r_state == ST_RD_T3);
  assign w_wr_phase = (r_state == ST_WR_T1) || (r_state == ST_WR_T2) || (r_state == ST_WR_T3);
  assign w_t1       = (r_state == ST_RD_T1) || (r_state == ST_WR_T1);
  assign w_t2       = (r_state == ST_RD_T2) || (r_state == ST_WR_T2);
  assign w_t3       = (r_state == ST_RD_T3) || (r_state == ST_WR_T3);
  assign w_done     = (r_state == ST_DONE);
  // 16-bit adds wrap naturally: PC 0xFFFF reads its operand from 0x0000.
  assign w_cyc_addr = w_wr_phase ? r_hl_q : (r_pc_q + 16'd1);
  assign w_pc_next  = r_pc_q + 16'd2;

  // One engine serves both M2 (read) and M3 (write); only the phase differs.
  z80_mem_cycle u_mem_cycle (
    .i_t1       (w_t1),
    .i_t2       (w_t2),
    .i_t3       (w_t3),
    .i_wr       (w_wr_phase),
    .i_addr     (w_cyc_addr),
    .i_wdata    (r_n_q),
    .i_wait_n   (wait_n),
    .o_addr     (addr),
    .o_data_out (data_out),
    .o_mreq_n   (mreq_n),
    .o_rd_n     (rd_n),
    .o_wr_n     (wr_n),
    .o_t2_done  (w_t2_done)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) r_state <= ST_RD_T1;
        ST_RD_T1: r_state <= ST_RD_T2;
        ST_RD_T2: if (w_t2_done) r_state <= ST_RD_T3;
        ST_RD_T3: r_state <= ST_WR_T1;
        ST_WR_T1: r_state <= ST_WR_T2;
        ST_WR_T2: if (w_t2_done) r_state <= ST_WR_T3;
        ST_WR_T3: r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers carry no reset; every output use is gated by state.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && start) begin
      r_pc_q <= pc_in;
      r_hl_q <= hl_in;
    end
    if (r_state == ST_RD_T3) begin
      r_n_q <= data_in;
    end
  end

  assign busy          = (r_state != ST_IDLE);
  assign done          = w_done;
  assign pc_next       = w_done ? w_pc_next : 16'h0000;
  assign fi_valid      = w_done;
  assign fi_insn       = w_done ? {r_n_q, OPC_LD_HL_N} : 16'h0000;
  assign fi_insn_len   = w_done ? LD_HL_N_LEN : 4'd0;
  assign fi_pc_rdata   = w_done ? r_pc_q : 16'h0000;
  assign fi_pc_wdata   = w_done ? w_pc_next : 16'h0000;
  assign fi_reg1_rnum  = w_done ? REG_HL : 3'd0;
  assign fi_reg1_rdata = w_done ? r_hl_q : 16'h0000;
  assign fi_mem_wr     = w_done;
  assign fi_mem_addr   = w_done ? r_hl_q : 16'h0000;
  assign fi_mem_wdata  = w_done ? r_n_q : 8'h00;

  logic w_unused;
  assign w_unused = w_rd_phase;

endmodule

// File: doc/z80_ld_hl_immed_seq.md
# z80_ld_hl_immed_seq

Multi-cycle sequencer that executes `LD (HL), n` (opcode 0x36) on the external Z80 memory bus once the decoder has completed the M1 opcode fetch. It runs the M2 operand read of `n` from PC+1 and the M3 write of `n` to the address in HL, honouring `wait_n`. On retirement it produces the next PC and a one-cycle Z80FI retirement record for formal checking against the instruction spec.

## Interface
Parameters: none.

Ports:
- `clk` in 1: sole clock; one clock = one T-state.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: decoder strobe. The opcode is 0x36 and M1 is finished. Sampled only in IDLE.
- `pc_in` in 16: PC of the opcode byte. Captured on the accepted `start`.
- `hl_in` in 16: HL value. Captured on the accepted `start`.
- `busy` out 1: high in every state except IDLE.
- `addr` out 16: memory address bus.
- `data_in` in 8: read data from memory.
- `data_out` out 8: write data to memory.
- `mreq_n` out 1: memory request, active-low.
- `rd_n` out 1: read strobe, active-low.
- `wr_n` out 1: write strobe, active-low.
- `wait_n` in 1: wait request, active-low. Sampled in T2 states.
- `done` out 1: one-cycle pulse on retirement.
- `pc_next` out 16: `pc_in + 2`, mod 2^16. Valid while `done` is high.
- `fi_valid` out 1: Z80FI retirement record valid. Equals `done`.
- `fi_insn` out 16: `{n, 8'h36}`.
- `fi_insn_len` out 4: constant 2.
- `fi_pc_rdata` out 16: captured `pc_in`.
- `fi_pc_wdata` out 16: equals `pc_next`.
- `fi_reg1_rnum` out 3: `REG_HL`.
- `fi_reg1_rdata` out 16: captured HL.
- `fi_mem_wr` out 1: 1 while `fi_valid` is high.
- `fi_mem_addr` out 16: captured HL.
- `fi_mem_wdata` out 8: `n`.

## Operation
- Registered state: `pc_q`, `hl_q`, `n_q`, and the FSM state.
- Transitions:
  - IDLE -> RD_T1 on `start`. Latch `pc_q` and `hl_q`.
  - RD_T1 -> RD_T2.
  - RD_T2 -> RD_T3 if `wait_n`=1; otherwise stay in RD_T2 (one wait state per cycle held).
  - RD_T3 -> WR_T1. Latch `n_q <= data_in` on this edge.
  - WR_T1 -> WR_T2.
  - WR_T2 -> WR_T3 if `wait_n`=1; otherwise stay in WR_T2.
  - WR_T3 -> DONE.
  - DONE -> IDLE.
- Bus outputs by state:
  - `addr` = `pc_q+1` in RD_T1..RD_T3 (16-bit wrap: 0xFFFF+1 = 0x0000).
  - `addr` = `hl_q` in WR_T1..WR_T3.
  - `addr` = 0 elsewhere.
  - `mreq_n` = 0 in RD_T1..RD_T3 and WR_T1..WR_T3.
  - `rd_n` = 0 in RD_T1..RD_T3.
  - `wr_n` = 0 in WR_T2 only, including any wait cycles spent there.
  - `data_out` = `n_q` in WR_T1..WR_T3, 0 elsewhere.
- `start` asserted while `busy` is ignored and has no side effects.
- `wait_n` is ignored outside RD_T2 and WR_T2.
- All `fi_*`, `done` and `pc_next` outputs are 0 outside DONE.
- Reset, including mid-operation, forces IDLE on the next edge. No `done` or `fi_valid` is produced for the aborted instruction.
- Reset values: `busy`=0, `addr`=0, `data_out`=0, `mreq_n`=1, `rd_n`=1, `wr_n`=1, `done`=0, all `fi_*`=0, `pc_next`=0.

## Timing
- All outputs are registered-state decodes. No combinational path from `data_in` or `wait_n` to any output.
- `start` accepted at edge k:
  - RD_T1..RD_T3 occupy cycles k+1..k+3.
  - WR_T1..WR_T3 occupy cycles k+4..k+6.
  - `done` is high in cycle k+7.
- Minimum latency `start` -> `done` is 7 cycles. Each cycle `wait_n`=0 is sampled in a T2 state adds exactly 1.
- Back-to-back: `start` may be accepted on the edge ending the IDLE cycle that follows DONE. Minimum issue interval is 8 cycles.
- `n_q` is stable from WR_T1 onward. `fi_mem_wdata` equals the byte present on `data_in` during RD_T3.

## Structure
- Shared package `z80_seq_pkg` holds:
  - the state enum (IDLE, RD_T1, RD_T2, RD_T3, WR_T1, WR_T2, WR_T3, DONE);
  - `OPC_LD_HL_N` = 8'h36.
- `REG_HL` is taken from `z80.vh`.
- One sub-module, `z80_mem_cycle`, is natural: a generic 3-T-state read/write cycle engine with wait insertion. This sequencer instantiates it for M2 and M3, and later sequencers reuse it.

## Test plan
- No wait: `pc_in`=0x1000, `hl_in`=0x8000, memory[0x1001]=0x5A.
  - Write of 0x5A to 0x8000, with `wr_n` low exactly 1 cycle.
  - `done` at k+7; `pc_next`=0x1002; `fi_insn`=0x5A36; `fi_mem_addr`=0x8000.
- Waits: 2 cycles `wait_n`=0 in RD_T2 and 1 in WR_T2.
  - `done` at k+10; `wr_n` low 2 cycles; correct data.
- Wrap: `pc_in`=0xFFFF.
  - Operand read at 0x0000; `pc_next`=0x0001.
  - `hl_in`=0xFFFF: write address 0xFFFF.
- `start` held high continuously for 20 cycles.
  - Exactly two instructions retire, with `done` at k+7 and k+15.
  - No bus activity in the IDLE cycles at k+8 and k+16.
- `reset_n`=0 during WR_T2.
  - Next cycle: IDLE, `mreq_n`=`wr_n`=1.
  - No `done`/`fi_valid`; a following `start` completes normally.
